// File: rtl/mixer_sequencer.sv
// mixer_sequencer: time-multiplexed vocoder mixer. Latches one frame of
// carrier/envelope channel words and runs one shared signed MAC across the
// channels, one channel per cycle, then emits a single 24-bit mixed sample.
// Optional build macro MIXER_SAT_EN: saturate the result to signed 24 bits
// instead of wrapping.
module mixer_sequencer #(
    parameter int unsigned N_FILTERS = 8
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        valid_in,
    input  logic [4:0]                  shift,
    input  logic [N_FILTERS-1:0]        channel_mask,
    input  logic signed [31:0]          carrier_channels  [N_FILTERS],
    input  logic signed [31:0]          envelope_channels [N_FILTERS],
    input  logic                        overrun_clr,
    output logic                        ready_out,
    output logic                        busy_out,
    output logic signed [23:0]          mixed_out,
    output logic                        valid_out,
    output logic                        overrun_out
);

    localparam int unsigned ACC_W = 64 + $clog2(N_FILTERS);
    localparam int unsigned IDX_W = $clog2(N_FILTERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FILTERS - 1);
`ifdef MIXER_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(24'sh7FFFFF);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(24'sh800000);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    accept_c;
    logic                    overrun_set_c;
    logic [IDX_W-1:0]        idx;
    logic signed [31:0]      car_l [N_FILTERS];
    logic signed [31:0]      env_l [N_FILTERS];
    logic [4:0]              shift_l;
    logic [N_FILTERS-1:0]    mask_l;
    logic signed [ACC_W-1:0] acc;
    logic signed [31:0]      env_sh_c;
    logic signed [63:0]      prod_c;
    logic signed [ACC_W-1:0] term_c;
    logic signed [23:0]      reduced_c;

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: accept in IDLE, one MAC per channel, one output cycle.
    always_comb begin
        state_nxt     = state;
        accept_c      = 1'b0;
        overrun_set_c = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    accept_c  = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                overrun_set_c = valid_in;
                if (idx == LAST_IDX) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                overrun_set_c = valid_in;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Frame payload capture; the live input arrays are ignored after accept.
    always_ff @(posedge clk_in) begin
        if (accept_c && !rst_in) begin
            car_l   <= carrier_channels;
            env_l   <= envelope_channels;
            shift_l <= shift;
            mask_l  <= channel_mask;
        end
    end

    // Per-channel product: full 32x32 signed multiply, sign-extended to the accumulator.
    always_comb begin
        env_sh_c = env_l[idx] >>> shift_l;
        prod_c   = 64'(car_l[idx]) * 64'(env_sh_c);
        term_c   = mask_l[idx] ? ACC_W'(prod_c) : '0;
    end

    // Accumulator and channel index; masked channels still take their cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx <= '0;
            acc <= '0;
        end else if (accept_c) begin
            idx <= '0;
            acc <= '0;
        end else if (state == MAC) begin
            acc <= acc + term_c;
            idx <= idx + IDX_W'(1);
        end
    end

    // Reduce the wide accumulator to the 24-bit output sample.
    always_comb begin
`ifdef MIXER_SAT_EN
        if (acc > SAT_MAX) begin
            reduced_c = 24'sh7FFFFF;
        end else if (acc < SAT_MIN) begin
            reduced_c = 24'sh800000;
        end else begin
            reduced_c = acc[23:0];
        end
`else
        reduced_c = acc[23:0];
`endif
    end

    // Registered outputs: handshake decodes, result, pulse and sticky overrun.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ready_out   <= 1'b1;
            busy_out    <= 1'b0;
            mixed_out   <= '0;
            valid_out   <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            ready_out <= (state_nxt == IDLE);
            busy_out  <= (state_nxt != IDLE);
            valid_out <= (state == OUT);
            if (state == OUT) begin
                mixed_out <= reduced_c;
            end
            if (overrun_set_c) begin
                overrun_out <= 1'b1;
            end else if (overrun_clr) begin
                overrun_out <= 1'b0;
            end
        end
    end

endmodule
